// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_scan_pkg;

  // Segment pattern with every segment dark (active-low bus {g,f,e,d,c,b,a}).
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Hex glyphs 0..F, active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Width of a counter covering 0..div-1, i.e. clog2(div); never less than 1 bit.
  function automatic int unsigned prescaler_width(input int unsigned div);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(div)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/hex_glyph.sv
// Combinational hex nibble to seven-segment glyph lookup.
module hex_glyph
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Table lookup of the active-low segment pattern.
  always_comb begin
    segs = GLYPH_TABLE[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with shadowed display
// data, per-digit blanking, decimal points, leading-zero suppression and an
// anti-ghosting dark interval at the start of every digit slot.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lzs,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            segs,
  output logic                  dp_out
);

  localparam int unsigned PW = prescaler_width(REFRESH_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]          pre;
  logic [IW-1:0]          idx;
  logic                   pre_wrap;
  logic                   in_blank;

  logic [4*DIGITS-1:0]    sh_value;
  logic [DIGITS-1:0]      sh_dp;
  logic [DIGITS-1:0]      sh_blank;

  logic [DIGITS-1:0]      suppress;
  logic [3:0]             cur_nibble;
  logic                   cur_dp;
  logic                   cur_dark;
  logic [6:0]             glyph;

  logic [DIGITS-1:0]      an_d;
  logic [6:0]             segs_d;
  logic                   dp_d;

  // Shadow copy of the display data; only updated on a load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_value <= '0;
      sh_dp    <= '0;
      sh_blank <= '0;
    end else if (load) begin
      sh_value <= value;
      sh_dp    <= dp;
      sh_blank <= blank;
    end
  end

  // Terminal count of the slot prescaler.
  always_comb begin
    pre_wrap = (pre == PRE_LAST);
  end

  // Slot prescaler and digit index; the index steps on each prescaler wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (pre_wrap) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Anti-ghosting window at the head of each slot (absent when BLANK_CYCLES is 0).
  if (BLANK_CYCLES > 0) begin : g_blank
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
    always_comb begin
      in_blank = (pre < BLANK_LIM);
    end
  end else begin : g_noblank
    always_comb begin
      in_blank = 1'b0;
    end
  end

  // Leading-zero suppression: walk from the most significant digit down,
  // keeping a running "everything above and here is zero without dp" flag.
  always_comb begin
    logic        run;
    int unsigned d;
    suppress = '0;
    run      = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      d   = DIGITS - 1 - k;
      run = run & (sh_value[4*d +: 4] == 4'h0) & ~sh_dp[d];
      if (d != 0) begin
        suppress[d] = run & lzs;
      end
    end
  end

  // Select the shadow data of the digit currently being scanned.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_dark   = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nibble = sh_value[4*i +: 4];
        cur_dp     = sh_dp[i];
        cur_dark   = sh_blank[i] | suppress[i];
      end
    end
  end

  hex_glyph u_glyph (
    .nibble (cur_nibble),
    .segs   (glyph)
  );

  // Next output pattern: all off in the blank window, dark digits keep their anode.
  always_comb begin
    an_d   = '1;
    segs_d = GLYPH_BLANK;
    dp_d   = 1'b1;
    if (!in_blank) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx == IW'(i)) begin
          an_d[i] = 1'b0;
        end
      end
      if (!cur_dark) begin
        segs_d = glyph;
        dp_d   = ~cur_dp;
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      an     <= '1;
      segs   <= GLYPH_BLANK;
      dp_out <= 1'b1;
    end else begin
      an     <= an_d;
      segs   <= segs_d;
      dp_out <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: two instances (DIV=4/BLANK=1 and
// DIV=2/BLANK=0) share stimulus; a time-since-reset reference model pushes
// expected pin states, a monitor pops and compares every cycle.
module tb_seg_scan_driver;

  localparam int DIGITS = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] segs;
    logic       dp;
  } disp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lzs = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;

  logic [3:0]  an_a, an_b;
  logic [6:0]  segs_a, segs_b;
  logic        dpo_a, dpo_b;

  disp_t q_a[$];
  disp_t q_b[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: cycles since reset plus the captured display data.
  int          t = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blank = '0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .lzs(lzs),
    .load(load), .an(an_a), .segs(segs_a), .dp_out(dpo_a)
  );

  seg_scan_driver #(.DIGITS(4), .REFRESH_DIV(2), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .lzs(lzs),
    .load(load), .an(an_b), .segs(segs_b), .dp_out(dpo_b)
  );

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1011000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Expected pins for the output that follows the tt-th edge after reset.
  function automatic disp_t ref_out(input int div, input int blk, input int tt,
                                    input logic [15:0] v, input logic [3:0] d,
                                    input logic [3:0] b, input logic l);
    disp_t r;
    int    pos, dig;
    bit    dark, all_zero;
    r.an = 4'hF; r.segs = 7'h7F; r.dp = 1'b1;
    pos = tt % div;
    dig = (tt / div) % DIGITS;
    if (pos < blk) return r;
    r.an[dig] = 1'b0;
    dark = b[dig];
    if (l && dig > 0) begin
      all_zero = 1'b1;
      for (int j = dig; j < DIGITS; j++)
        if (v[4*j +: 4] != 4'h0 || d[j]) all_zero = 1'b0;
      if (all_zero) dark = 1'b1;
    end
    if (!dark) begin
      r.segs = ref_glyph(v[4*dig +: 4]);
      r.dp   = ~d[dig];
    end
    return r;
  endfunction

  // Model: on each edge predict the next registered output, then update state.
  always @(posedge clk) begin
    disp_t off;
    off.an = 4'hF; off.segs = 7'h7F; off.dp = 1'b1;
    if (rst) begin
      q_a.push_back(off);
      q_b.push_back(off);
      t = 0; m_val = '0; m_dp = '0; m_blank = '0;
    end else begin
      q_a.push_back(ref_out(4, 1, t, m_val, m_dp, m_blank, lzs));
      q_b.push_back(ref_out(2, 0, t, m_val, m_dp, m_blank, lzs));
      if (load) begin
        m_val = value; m_dp = dp; m_blank = blank;
      end
      t = t + 1;
    end
  end

  // Monitor: one expected entry per instance per cycle.
  initial begin
    disp_t e;
    forever begin
      @(posedge clk);
      #1;
      vectors++;
      if (q_a.size() == 0) begin
        miscompares++;
        $display("FAIL dut_a_noexp: no expected entry at time %0t", $time);
      end else begin
        e = q_a.pop_front();
        if ({an_a, segs_a, dpo_a} !== e) begin
          miscompares++;
          $display("FAIL dut_a t=%0d: got an=%b segs=%b dp=%b, expected an=%b segs=%b dp=%b",
                   t, an_a, segs_a, dpo_a, e.an, e.segs, e.dp);
        end
      end
      vectors++;
      if (q_b.size() == 0) begin
        miscompares++;
        $display("FAIL dut_b_noexp: no expected entry at time %0t", $time);
      end else begin
        e = q_b.pop_front();
        if ({an_b, segs_b, dpo_b} !== e) begin
          miscompares++;
          $display("FAIL dut_b t=%0d: got an=%b segs=%b dp=%b, expected an=%b segs=%b dp=%b",
                   t, an_b, segs_b, dpo_b, e.an, e.segs, e.dp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    value = v; dp = d; blank = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Wait (bounded) until the model's cycle count satisfies slot/phase for DIV=4.
  task automatic wait_phase(input int dig, input int pos, input string tag);
    int n;
    n = 0;
    while (!(((t / 4) % DIGITS) == dig && (t % 4) == pos) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      miscompares++;
      $display("FAIL %s: phase dig=%0d pos=%0d not reached, t=%0d", tag, dig, pos, t);
    end
  endtask

  initial begin
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;

    // Scan order with 1234.
    do_load(16'h1234, 4'b0000, 4'b0000);
    cyc(40);

    // Glyph sweep on digit 0.
    lzs = 1'b0;
    for (int n = 0; n < 16; n++) begin
      do_load(16'(n), 4'b0000, 4'b0000);
      cyc(16);
    end

    // Leading-zero suppression, then with dp[3] defeating it.
    lzs = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    cyc(20);
    do_load(16'h0050, 4'b1000, 4'b0000);
    cyc(20);

    // Blank and dp masks.
    lzs = 1'b0;
    do_load(16'h8888, 4'b0101, 4'b0100);
    cyc(20);

    // Shadow hold: inputs churn without load.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      value = 16'($urandom); dp = 4'($urandom); blank = 4'($urandom);
    end

    // Load coinciding with a prescaler wrap.
    wait_phase(1, 3, "wrap_load");
    value = 16'hABCD; dp = 4'b0010; blank = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cyc(20);

    // Reset while digit 2 is active.
    wait_phase(2, 1, "mid_reset");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc(20);

    // Randomized traffic with occasional resets, biased toward leading zeros.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 79) == 0);
      load  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) lzs = ~lzs;
      value = 16'($urandom) >> $urandom_range(0, 16);
      dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
    end
    rst = 1'b0; load = 1'b0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
